// File: rtl/nmos_phase_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : nmos_phase_gen_if
// Description : Control/status bundle of the two-phase enable generator.
//               Carries the stretch line when NMOS_PHASE_STRETCH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nmos_phase_gen_if #(
    parameter int CYC_W = 32
);
    logic             run_en;
    logic             step;
`ifdef NMOS_PHASE_STRETCH_EN
    logic             stretch;
`endif
    logic             phi1;
    logic             phi2;
    logic             phi1_first;
    logic             phi2_last;
    logic             idle;
    logic [CYC_W-1:0] cycle_cnt;

`ifdef NMOS_PHASE_STRETCH_EN
    modport master (
        output run_en, step, stretch,
        input  phi1, phi2, phi1_first, phi2_last, idle, cycle_cnt
    );
    modport slave (
        input  run_en, step, stretch,
        output phi1, phi2, phi1_first, phi2_last, idle, cycle_cnt
    );
`else
    modport master (
        output run_en, step,
        input  phi1, phi2, phi1_first, phi2_last, idle, cycle_cnt
    );
    modport slave (
        input  run_en, step,
        output phi1, phi2, phi1_first, phi2_last, idle, cycle_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nmos_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : nmos_phase_gen
// Description : Two-phase non-overlapping clock-enable generator (phi1/phi2)
//               with free-run, stop-at-boundary and single-step modes.
//               Optional P2 stretch input under NMOS_PHASE_STRETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nmos_phase_gen #(
    parameter int PHI1_LEN = 2,
    parameter int PHI2_LEN = 2,
    parameter int GAP_LEN  = 1,
    parameter int CNT_W    = 8,
    parameter int CYC_W    = 32
) (
    input  logic              main_clk,
    input  logic              main_rst_n,
    nmos_phase_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_G1   = 3'd2,
        S_P2   = 3'd3,
        S_G2   = 3'd4
    } state_t;

    localparam int               C_CNT_MAX = (1 << CNT_W) - 1;
    localparam bit               C_HAS_GAP = (GAP_LEN != 0);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CYC_W-1:0] C_CYC_ONE = CYC_W'(1);
    localparam logic [CNT_W-1:0] C_PHI1_LD = CNT_W'(PHI1_LEN - 1);
    localparam logic [CNT_W-1:0] C_PHI2_LD = CNT_W'(PHI2_LEN - 1);
    localparam logic [CNT_W-1:0] C_GAP_LD  = C_HAS_GAP ? CNT_W'(GAP_LEN - 1) : '0;

    // Configuration sanity: lengths must fit the phase counter.
    if (PHI1_LEN < 1 || PHI1_LEN > C_CNT_MAX) begin : g_chk_phi1
        $error("nmos_phase_gen: PHI1_LEN out of range");
    end
    if (PHI2_LEN < 1 || PHI2_LEN > C_CNT_MAX) begin : g_chk_phi2
        $error("nmos_phase_gen: PHI2_LEN out of range");
    end
    if (GAP_LEN < 0 || GAP_LEN > C_CNT_MAX) begin : g_chk_gap
        $error("nmos_phase_gen: GAP_LEN out of range");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CYC_W-1:0] cyc_q,   cyc_d;
    logic             phi1_q,  phi1_d;
    logic             phi2_q,  phi2_d;
    logic             first_q, first_d;
    logic             last_q,  last_d;
    logic             idle_q,  idle_d;
    logic             w_hold_p2;
    logic             w_cnt_zero;

`ifdef NMOS_PHASE_STRETCH_EN
    assign w_hold_p2 = bus.stretch;
`else
    assign w_hold_p2 = 1'b0;
`endif

    assign w_cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run_en || bus.step) begin
                    state_d = S_P1;
                    cnt_d   = C_PHI1_LD;
                end
            end
            S_P1: begin
                if (!w_cnt_zero) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end else if (C_HAS_GAP) begin
                    state_d = S_G1;
                    cnt_d   = C_GAP_LD;
                end else begin
                    state_d = S_P2;
                    cnt_d   = C_PHI2_LD;
                end
            end
            S_G1: begin
                if (!w_cnt_zero) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end else begin
                    state_d = S_P2;
                    cnt_d   = C_PHI2_LD;
                end
            end
            S_P2: begin
                if (!w_cnt_zero) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end else if (!w_hold_p2) begin
                    cyc_d = cyc_q + C_CYC_ONE;
                    if (C_HAS_GAP) begin
                        state_d = S_G2;
                        cnt_d   = C_GAP_LD;
                    end else if (bus.run_en) begin
                        state_d = S_P1;
                        cnt_d   = C_PHI1_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            S_G2: begin
                if (!w_cnt_zero) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end else if (bus.run_en) begin
                    state_d = S_P1;
                    cnt_d   = C_PHI1_LD;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch with the state.
    always_comb begin
        phi1_d  = (state_d == S_P1);
        first_d = (state_d == S_P1) && (state_q != S_P1);
        phi2_d  = (state_d == S_P2);
        last_d  = (state_d == S_P2) && (cnt_d == '0);
        idle_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
            first_q <= first_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.phi1       = phi1_q;
    assign bus.phi2       = phi2_q;
    assign bus.phi1_first = first_q;
    // While stretched, the held P2 clocks are not the last one.
    assign bus.phi2_last  = last_q & ~w_hold_p2;
    assign bus.idle       = idle_q;
    assign bus.cycle_cnt  = cyc_q;

endmodule
`default_nettype wire
